wr_ptr_gen: RTL

Write-side pointer generator for the asynchronous FIFO, in the write clock domain (clk_A).
- Accepts write requests and qualifies them against the `full` flag produced by the write-domain full-detection stage.
- Drives the dual-port memory write port.
- Advances the binary write pointer `wr_ptr`, which it feeds to that full-detection stage.
- Advances the registered Gray pointer `g_wr_ptr`, which crosses to the read domain through the 2-flop synchroniser.

---
 rtl/wr_ptr_gen_if.sv | 45 ++++
 rtl/wr_ptr_gen.sv | 97 +++++++++
 2 files changed

// File: rtl/wr_ptr_gen_if.sv
// Write-side bus of the async FIFO: request/ack/overflow handshake plus
// the dual-port memory write port and the pointers handed to the
// full-detection stage and the clock-domain crossing.
// WR_LEVEL_EN adds the synchronised read pointer and fill-level signals.
interface wr_ptr_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  ovf_clr;
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   g_wr_ptr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wr_ack;
  logic                  overflow;
`ifdef WR_LEVEL_EN
  logic [ADDR_WIDTH:0]   sync_b_rd_ptr;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  almost_full;
`endif

  // Pointer generator side
  modport slave (
    input  wr_en, wr_data, full, ovf_clr,
`ifdef WR_LEVEL_EN
    input  sync_b_rd_ptr,
    output wr_level, almost_full,
`endif
    output wr_ptr, g_wr_ptr, mem_we, mem_waddr, mem_wdata, wr_ack, overflow
  );

  // Requester / surrounding FIFO side
  modport master (
    output wr_en, wr_data, full, ovf_clr,
`ifdef WR_LEVEL_EN
    output sync_b_rd_ptr,
    input  wr_level, almost_full,
`endif
    input  wr_ptr, g_wr_ptr, mem_we, mem_waddr, mem_wdata, wr_ack, overflow
  );
endinterface

// File: rtl/wr_ptr_gen.sv
// Write-side pointer generator of the asynchronous FIFO (clk_A domain).
// Qualifies write requests against full, drives the memory write port,
// and advances the binary and registered Gray write pointers.
// Optional macro WR_LEVEL_EN adds registered fill level and almost_full.
module wr_ptr_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2
) (
  input  logic         clk_A,
  input  logic         rst,
  wr_ptr_gen_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // A threshold outside 0..DEPTH could never (or always) assert almost_full
  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("wr_ptr_gen: AF_THRESH out of range 0..DEPTH");
  end

  logic                accept;
  logic                reject;
  logic [ADDR_WIDTH:0] ptr_q;
  logic [ADDR_WIDTH:0] gray_q;
  logic [ADDR_WIDTH:0] ptr_inc;
  logic [ADDR_WIDTH:0] ptr_next;
  logic                ack_q;
  logic                ovf_q;

  // Write qualification; rst gating keeps mem_we low throughout reset
  always_comb begin
    accept   = bus.wr_en & ~bus.full & rst;
    reject   = bus.wr_en & bus.full;
    ptr_inc  = ptr_q + 1'b1;
    ptr_next = accept ? ptr_inc : ptr_q;
  end

  // Pointers and ack; Gray is derived from the next binary value and
  // registered so the crossing signal never glitches
  always_ff @(posedge clk_A or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      gray_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= accept;
      if (accept) begin
        ptr_q  <= ptr_inc;
        gray_q <= ptr_inc ^ (ptr_inc >> 1);
      end
    end
  end

  // Sticky overflow: a rejected write wins over a simultaneous clear
  always_ff @(posedge clk_A or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (reject) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef WR_LEVEL_EN
  logic [ADDR_WIDTH:0] level_next;
  logic [ADDR_WIDTH:0] level_q;
  logic                af_q;

  // Fill level against the synchronised read pointer (pessimistic)
  always_comb begin
    level_next = ptr_next - bus.sync_b_rd_ptr;
  end

  // Registered level and almost-full flag
  always_ff @(posedge clk_A or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      af_q    <= 1'b0;
    end else begin
      level_q <= level_next;
      af_q    <= (int'(level_next) >= AF_THRESH);
    end
  end

  assign bus.wr_level    = level_q;
  assign bus.almost_full = af_q;
`endif

  assign bus.mem_we    = accept;
  assign bus.mem_waddr = ptr_q[ADDR_WIDTH-1:0];
  assign bus.mem_wdata = bus.wr_data;
  assign bus.wr_ptr    = ptr_q;
  assign bus.g_wr_ptr  = gray_q;
  assign bus.wr_ack    = ack_q;
  assign bus.overflow  = ovf_q;
endmodule
